// File: rtl/puf_auth_pkg.sv
// rtl/puf_auth_pkg.sv - shared types and constants for the PUF auth verifier (PUF_AUTH_MAJORITY_EN selects NUM_EVAL)
package puf_auth_pkg;

  typedef enum logic [2:0] {IDLE, ARM, WAIT, CMP, DONE} state_t;
  typedef enum logic {AUTH = 1'b0, ENROLL = 1'b1} mode_t;

  localparam int ARM_CYC = 2;

`ifdef PUF_AUTH_MAJORITY_EN
  localparam int NUM_EVAL = 3;
`else
  localparam int NUM_EVAL = 1;
`endif

endpackage

// File: rtl/puf_auth_verifier_if.sv
// rtl/puf_auth_verifier_if.sv - host request/result interface of the PUF auth verifier
interface puf_auth_verifier_if #(
  parameter int CHAL_W = 8,
  parameter int IDX_W  = 4,
  parameter int HD_W   = 5
);
  logic              start;
  logic              mode;
  logic [IDX_W-1:0]  idx;
  logic [CHAL_W-1:0] chal_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic              err;
  logic [HD_W-1:0]   hd;

  modport master (
    output start, mode, idx, chal_in,
    input  busy, done, pass, err, hd
  );

  modport slave (
    input  start, mode, idx, chal_in,
    output busy, done, pass, err, hd
  );
endinterface

// File: rtl/puf_hamming_popcount.sv
// rtl/puf_hamming_popcount.sv - combinational Hamming distance between two responses
module puf_hamming_popcount #(
  parameter  int RESP_W = 24,
  localparam int HD_W   = $clog2(RESP_W + 1)
) (
  input  logic [RESP_W-1:0] a,
  input  logic [RESP_W-1:0] b,
  output logic [HD_W-1:0]   count
);

  logic [RESP_W-1:0] diff;

  always_comb begin
    diff  = a ^ b;
    count = '0;
    for (int i = 0; i < RESP_W; i++) begin
      count = count + HD_W'(diff[i]);
    end
  end

endmodule

// File: rtl/puf_auth_verifier.sv
// rtl/puf_auth_verifier.sv - arbiter PUF challenge issuer with CRP table enroll/auth (PUF_AUTH_MAJORITY_EN: 3-eval majority)
module puf_auth_verifier
  import puf_auth_pkg::*;
#(
  parameter  int CHAL_W    = 8,
  parameter  int RESP_W    = 24,
  parameter  int NUM_CRP   = 16,
  parameter  int HD_THRESH = 3,
  parameter  int RESP_LAT  = RESP_W + 2,
  localparam int IDX_W     = $clog2(NUM_CRP),
  localparam int HD_W      = $clog2(RESP_W + 1)
) (
  input  logic                clk,
  input  logic                reset,
  puf_auth_verifier_if.slave  host,
  output logic [CHAL_W-1:0]   puf_challenge,
  output logic                puf_rst_n,
  input  logic [RESP_W-1:0]   puf_response
);

  localparam int CNT_W = $clog2(RESP_LAT + 1);

  state_t            state;
  mode_t             mode_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        eval_cnt;
  logic              busy_q, done_q, pass_q, err_q;
  logic [HD_W-1:0]   hd_q;
  logic [HD_W-1:0]   hd_calc;
  logic [RESP_W-1:0] samp0;
  logic [RESP_W-1:0] sample;

  logic [RESP_W-1:0]  crp_data [NUM_CRP];
  logic [NUM_CRP-1:0] valid_q;

`ifdef PUF_AUTH_MAJORITY_EN
  logic [RESP_W-1:0] samp1, samp2;
  assign sample = (samp0 & samp1) | (samp0 & samp2) | (samp1 & samp2);
`else
  assign sample = samp0;
`endif

  assign host.busy = busy_q;
  assign host.done = done_q;
  assign host.pass = pass_q;
  assign host.err  = err_q;
  assign host.hd   = hd_q;

  puf_hamming_popcount #(.RESP_W(RESP_W)) u_popcount (
    .a     (sample),
    .b     (crp_data[idx_q]),
    .count (hd_calc)
  );

  // Table payload is deliberately left out of reset; only the valid bits gate its use.
  always_ff @(posedge clk) begin
    if (state == CMP && mode_q == ENROLL) begin
      crp_data[idx_q] <= sample;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mode_q        <= AUTH;
      idx_q         <= '0;
      cnt           <= '0;
      eval_cnt      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_q         <= 1'b0;
      hd_q          <= '0;
      samp0         <= '0;
`ifdef PUF_AUTH_MAJORITY_EN
      samp1         <= '0;
      samp2         <= '0;
`endif
      puf_challenge <= '0;
      puf_rst_n     <= 1'b0;
      valid_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (host.start) begin
            mode_q        <= mode_t'(host.mode);
            idx_q         <= host.idx;
            puf_challenge <= host.chal_in;
            busy_q        <= 1'b1;
            pass_q        <= 1'b0;
            hd_q          <= '0;
            cnt           <= '0;
            eval_cnt      <= '0;
            if (host.mode == AUTH && !valid_q[host.idx]) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              err_q <= 1'b0;
              state <= ARM;
            end
          end
        end
        ARM: begin
          if (cnt == CNT_W'(ARM_CYC - 1)) begin
            cnt       <= '0;
            puf_rst_n <= 1'b1;
            state     <= WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(RESP_LAT - 1)) begin
            cnt       <= '0;
            samp0     <= puf_response;
`ifdef PUF_AUTH_MAJORITY_EN
            samp1     <= samp0;
            samp2     <= samp1;
`endif
            puf_rst_n <= 1'b0;
            if (eval_cnt == 2'(NUM_EVAL - 1)) begin
              state <= CMP;
            end else begin
              eval_cnt <= eval_cnt + 1'b1;
              state    <= ARM;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CMP: begin
          if (mode_q == ENROLL) begin
            valid_q[idx_q] <= 1'b1;
            pass_q         <= 1'b1;
            hd_q           <= '0;
          end else begin
            pass_q <= (hd_calc <= HD_W'(HD_THRESH));
            hd_q   <= hd_calc;
          end
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          // The unenrolled-AUTH shortcut arrives here without done set, so it spends one extra cycle.
          if (done_q) begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
